// File: rtl/turn_signal_nsl.sv
// rtl/turn_signal_nsl.sv - next-state stage of the tail-light turn-signal FSM
//
// Synchronises the raw switch and side inputs, divides clk into a blink
// tick and computes the next lamp state from the fed-back current state.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   CurrentState registered state from the current-state register stage
//   SW           raw switches: SW[0] turn enable, SW[1] hazard
//   turn_side    raw side select: 0 left, 1 right
//   NextState    next state for the current-state register stage
//   tick         registered one-cycle blink-step pulse

module turn_signal_nsl #(
   parameter int TICK_DIV = 12500000,
   parameter int CNT_W    = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] CurrentState,
   input  logic [1:0] SW,
   input  logic       turn_side,
   output logic [2:0] NextState,
   output logic       tick
);

   localparam logic [2:0] ST_OFF = 3'b000;
   localparam logic [2:0] ST_L1  = 3'b001;
   localparam logic [2:0] ST_L2  = 3'b010;
   localparam logic [2:0] ST_L3  = 3'b011;
   localparam logic [2:0] ST_R1  = 3'b100;
   localparam logic [2:0] ST_R2  = 3'b101;
   localparam logic [2:0] ST_R3  = 3'b110;
   localparam logic [2:0] ST_HAZ = 3'b111;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      MODE_IDLE,
      MODE_LEFT,
      MODE_RIGHT,
      MODE_HAZ
   } mode_t;

   logic [1:0]       sw_meta;
   logic [1:0]       sw_sync;
   logic             side_meta;
   logic             side_sync;
   logic             s_en;
   logic             s_haz;
   logic             s_side;
   logic [CNT_W-1:0] count;
   mode_t            mode;

   // Two-flop synchronisers; no debouncing beyond this.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_meta   <= 2'b00;
         sw_sync   <= 2'b00;
         side_meta <= 1'b0;
         side_sync <= 1'b0;
      end else begin
         sw_meta   <= SW;
         sw_sync   <= sw_meta;
         side_meta <= turn_side;
         side_sync <= side_meta;
      end
   end

   assign s_en   = sw_sync[0];
   assign s_haz  = sw_sync[1];
   assign s_side = side_sync;

   // Free-running prescaler; tick is high in the cycle after the wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (count == CNT_LAST) begin
         count <= '0;
         tick  <= 1'b1;
      end else begin
         count <= count + CNT_W'(1);
         tick  <= 1'b0;
      end
   end

   // Hazard outranks turn.
   always_comb begin
      mode = MODE_IDLE;
      if (s_haz) begin
         mode = MODE_HAZ;
      end else if (s_en) begin
         mode = s_side ? MODE_RIGHT : MODE_LEFT;
      end
   end

   // Any state foreign to the current mode falls to OFF first, so a mode
   // change always shows one dark tick period before the new pattern.
   always_comb begin
      NextState = CurrentState;
      if (reset) begin
         NextState = ST_OFF;
      end else if (tick) begin
         NextState = ST_OFF;
         case (mode)
            MODE_HAZ: begin
               if (CurrentState == ST_OFF) NextState = ST_HAZ;
            end
            MODE_LEFT: begin
               case (CurrentState)
                  ST_OFF:  NextState = ST_L1;
                  ST_L1:   NextState = ST_L2;
                  ST_L2:   NextState = ST_L3;
                  default: NextState = ST_OFF;
               endcase
            end
            MODE_RIGHT: begin
               case (CurrentState)
                  ST_OFF:  NextState = ST_R1;
                  ST_R1:   NextState = ST_R2;
                  ST_R2:   NextState = ST_R3;
                  default: NextState = ST_OFF;
               endcase
            end
            default: NextState = ST_OFF;
         endcase
      end
   end

endmodule

// File: tb/tb_turn_signal_nsl.sv
// tb/tb_turn_signal_nsl.sv - scoreboard bench for turn_signal_nsl

module tb_turn_signal_nsl;

   localparam int TICK_DIV = 4;
   localparam int CNT_W    = 3;

   typedef struct packed {
      logic       tick;
      logic [2:0] ns;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] SW = 2'b00;
   logic       turn_side = 1'b0;
   logic [2:0] NextState;
   logic       tick;

   logic [2:0] cs_reg = 3'b000;
   logic       force_en = 1'b0;
   logic [2:0] force_val = 3'b000;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t exp_q[$];
   logic [2:0] hist_q[$];   // raw {haz, en, side} samples, newest first
   int cyc = 0;

   turn_signal_nsl #(
      .TICK_DIV(TICK_DIV),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .CurrentState(cs_reg),
      .SW          (SW),
      .turn_side   (turn_side),
      .NextState   (NextState),
      .tick        (tick)
   );

   always #5 clk = ~clk;

   // Current-state register stage, with an override to inject arbitrary states.
   always @(posedge clk) begin
      cs_reg <= force_en ? force_val : NextState;
   end

   function automatic logic [2:0] ref_next(logic [2:0] cs, logic haz, logic en, logic side);
      logic [2:0] seq [4];
      if (haz) return (cs == 3'b000) ? 3'b111 : 3'b000;
      if (!en) return 3'b000;
      if (side) seq = '{3'b000, 3'b100, 3'b101, 3'b110};
      else      seq = '{3'b000, 3'b001, 3'b010, 3'b011};
      for (int i = 0; i < 4; i++)
         if (seq[i] == cs) return seq[(i + 1) % 4];
      return 3'b000;
   endfunction

   // Reference model: inputs seen two edges late, tick every TICK_DIV edges.
   always @(posedge clk) begin
      exp_t e;
      logic [2:0] synced;
      if (reset) begin
         hist_q.delete();
         cyc = 0;
      end else begin
         hist_q.push_front({SW[1], SW[0], turn_side});
         if (hist_q.size() > 4) void'(hist_q.pop_back());
         cyc++;
      end
      #1;
      synced = (hist_q.size() >= 2) ? hist_q[1] : 3'b000;
      e.tick = !reset && cyc > 0 && (cyc % TICK_DIV) == 0;
      if (reset)       e.ns = 3'b000;
      else if (e.tick) e.ns = ref_next(cs_reg, synced[2], synced[1], synced[0]);
      else             e.ns = cs_reg;
      exp_q.push_back(e);
   end

   // Monitor: compare each cycle's output against the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (tick !== e.tick || NextState !== e.ns) begin
            n_bad++;
            $display("FAIL cycle_out t=%0t cs=%b got tick=%b ns=%b need tick=%b ns=%b",
                     $time, cs_reg, tick, NextState, e.tick, e.ns);
         end
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      bit found;

      // Reset held 3 cycles, then idle.
      step(3);
      reset = 1'b0;
      step(14);

      // Left sequence.
      SW = 2'b01; turn_side = 1'b0;
      step(28);

      // Right sequence.
      turn_side = 1'b1;
      step(24);

      // Left until L2, then hazard.
      turn_side = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1);
         if (cs_reg == 3'b010) found = 1;
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL reach_l2 got cs=%b need cs=010", cs_reg);
      end
      SW = 2'b11;
      step(20);

      // Right-sequence state while in left mode.
      SW = 2'b01; turn_side = 1'b0;
      step(6);
      force_val = 3'b101; force_en = 1'b1;
      step(1);
      force_en = 1'b0;
      step(10);

      // Randomised inputs and occasional injected states.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) SW = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) turn_side = 1'($urandom_range(0, 1));
         force_en = ($urandom_range(0, 15) == 0);
         force_val = 3'($urandom_range(0, 7));
         step(1);
      end
      force_en = 1'b0;

      // Asynchronous reset mid-cycle while at L3.
      SW = 2'b01; turn_side = 1'b0;
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         step(1);
         if (cs_reg == 3'b011) found = 1;
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL reach_l3 got cs=%b need cs=011", cs_reg);
      end
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (NextState !== 3'b000 || tick !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset got tick=%b ns=%b need tick=0 ns=000", tick, NextState);
      end
      step(2);
      reset = 1'b0;
      step(20);

      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
